// File: rtl/address_display_decoder.sv
// address_display_decoder
// Watches the scanned, active-low seven-segment bus of the address display,
// filters transient patterns, decodes each stable digit back to BCD and
// assembles ones/tens/hundreds into a 9-bit binary address.
//
// Ports
//    clk            system clock, rising edge
//    reset          synchronous reset, active low
//    sseg_indicator segment lines, active low; bit7 = dp (ignored), bits6:0 = g..a
//    digits         digit selects, active low; 1110 ones, 1101 tens, 1011 hundreds, 1111 blank
//    address_line   last successfully decoded address
//    address_valid  one-cycle pulse when address_line is updated
//    decode_error   one-cycle pulse on a rejected digit or frame
//
// state         | meaning
// --------------+-------------------------------------------------
// WAIT_ONES     | idle / expecting the ones digit of a new frame
// WAIT_TENS     | ones latched, expecting tens
// WAIT_HUNDREDS | ones and tens latched, expecting hundreds
// COMMIT        | full frame latched; range check and publish

module address_display_decoder #(
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sseg_indicator,
   input  logic [3:0] digits,
   output logic [8:0] address_line,
   output logic       address_valid,
   output logic       decode_error
);

   typedef enum logic [1:0] {WAIT_ONES, WAIT_TENS, WAIT_HUNDREDS, COMMIT} state_t;

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
   localparam logic [3:0] SEL_ONES   = 4'b1110;
   localparam logic [3:0] SEL_TENS   = 4'b1101;
   localparam logic [3:0] SEL_HUNDS  = 4'b1011;
   localparam logic [3:0] SEL_BLANK  = 4'b1111;

   state_t     state_q, state_d;
   logic [6:0] seg_q, seg_d;
   logic [3:0] dig_q, dig_d;
   logic [3:0] stable_cnt_q, stable_cnt_d;
   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] hunds_q, hunds_d;
   logic       pend_v_q, pend_v_d;
   logic [6:0] pend_seg_q, pend_seg_d;
   logic [3:0] pend_dig_q, pend_dig_d;
   logic [8:0] addr_q, addr_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;

   logic       pair_changed;
   logic       digit_event;
   logic       ev_v;
   logic [6:0] ev_seg;
   logic [3:0] ev_dig;
   logic [3:0] ev_val;
   logic       seg_ok;
   logic [9:0] value;
   logic       unused_dp;

   assign unused_dp = sseg_indicator[7];

   // Input stage and stability counter. The event is taken from the edge at
   // which the counter arrives at STABLE_MAX, so the data decoded is the
   // pair being registered at that same edge.
   always_comb begin
      seg_d        = sseg_indicator[6:0];
      dig_d        = digits;
      pair_changed = {seg_d, dig_d} != {seg_q, dig_q};
      stable_cnt_d = stable_cnt_q;
      if (pair_changed) begin
         stable_cnt_d = 4'd1;
      end else if (stable_cnt_q != STABLE_MAX) begin
         stable_cnt_d = stable_cnt_q + 4'd1;
      end
      // pair_changed term covers STABLE_CYCLES = 1, where the count never moves.
      digit_event = (stable_cnt_d == STABLE_MAX) && (pair_changed || (stable_cnt_q != STABLE_MAX));
   end

   // Event source: a digit arriving during COMMIT is parked and replayed the
   // next cycle ahead of any live event.
   always_comb begin
      ev_v       = 1'b0;
      ev_seg     = seg_d;
      ev_dig     = dig_d;
      pend_v_d   = pend_v_q;
      pend_seg_d = pend_seg_q;
      pend_dig_d = pend_dig_q;
      if (state_q == COMMIT) begin
         if (digit_event && (dig_d != SEL_BLANK) && !pend_v_q) begin
            pend_v_d   = 1'b1;
            pend_seg_d = seg_d;
            pend_dig_d = dig_d;
         end
      end else if (pend_v_q) begin
         ev_v     = 1'b1;
         ev_seg   = pend_seg_q;
         ev_dig   = pend_dig_q;
         pend_v_d = 1'b0;
         if (digit_event && (dig_d != SEL_BLANK)) begin
            pend_v_d   = 1'b1;
            pend_seg_d = seg_d;
            pend_dig_d = dig_d;
         end
      end else begin
         ev_v = digit_event;
      end
   end

   always_comb begin
      seg_ok = 1'b1;
      ev_val = 4'd0;
      case (ev_seg)
         7'h40:   ev_val = 4'd0;
         7'h79:   ev_val = 4'd1;
         7'h24:   ev_val = 4'd2;
         7'h30:   ev_val = 4'd3;
         7'h19:   ev_val = 4'd4;
         7'h12:   ev_val = 4'd5;
         7'h02:   ev_val = 4'd6;
         7'h78:   ev_val = 4'd7;
         7'h00:   ev_val = 4'd8;
         7'h10:   ev_val = 4'd9;
         default: seg_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      hunds_d = hunds_q;
      addr_d  = addr_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      value   = (10'(hunds_q) * 10'd100) + (10'(tens_q) * 10'd10) + 10'(ones_q);
      if (state_q == COMMIT) begin
         if (value <= 10'd511) begin
            addr_d  = value[8:0];
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
         state_d = WAIT_ONES;
      end else if (ev_v && (ev_dig != SEL_BLANK)) begin
         if (!seg_ok) begin
            err_d   = 1'b1;
            state_d = WAIT_ONES;
         end else begin
            case (ev_dig)
               SEL_ONES: begin
                  ones_d  = ev_val;
                  state_d = WAIT_TENS;
               end
               SEL_TENS: begin
                  if (state_q == WAIT_TENS) begin
                     tens_d  = ev_val;
                     state_d = WAIT_HUNDREDS;
                  end else begin
                     err_d   = 1'b1;
                     state_d = WAIT_ONES;
                  end
               end
               SEL_HUNDS: begin
                  if (state_q == WAIT_HUNDREDS) begin
                     hunds_d = ev_val;
                     state_d = COMMIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = WAIT_ONES;
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = WAIT_ONES;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= WAIT_ONES;
         seg_q        <= '0;
         dig_q        <= '0;
         stable_cnt_q <= '0;
         ones_q       <= '0;
         tens_q       <= '0;
         hunds_q      <= '0;
         pend_v_q     <= 1'b0;
         pend_seg_q   <= '0;
         pend_dig_q   <= '0;
         addr_q       <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
         stable_cnt_q <= stable_cnt_d;
         ones_q       <= ones_d;
         tens_q       <= tens_d;
         hunds_q      <= hunds_d;
         pend_v_q     <= pend_v_d;
         pend_seg_q   <= pend_seg_d;
         pend_dig_q   <= pend_dig_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign address_line  = addr_q;
   assign address_valid = valid_q;
   assign decode_error  = err_q;

endmodule

// File: tb/tb_address_display_decoder.sv
module tb_address_display_decoder;

   localparam int S = 3;
   localparam logic [3:0] ONES  = 4'b1110;
   localparam logic [3:0] TENS  = 4'b1101;
   localparam logic [3:0] HUNDS = 4'b1011;
   localparam logic [3:0] BLANK = 4'b1111;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sseg_indicator;
   logic [3:0] digits;
   logic [8:0] address_line;
   logic       address_valid;
   logic       decode_error;

   always #5 clk = ~clk;

   address_display_decoder #(.STABLE_CYCLES(S)) dut (
      .clk           (clk),
      .reset         (reset),
      .sseg_indicator(sseg_indicator),
      .digits        (digits),
      .address_line  (address_line),
      .address_valid (address_valid),
      .decode_error  (decode_error)
   );

   // Display codes for 0..9, dp off.
   logic [7:0] seg_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   int valid_seen = 0;
   int err_seen   = 0;
   int last_valid_cyc = -1;
   int last_set_cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
   endtask

   // Reference model: run length of identical input samples, and a frame
   // built as a list of accepted digits in ones, tens, hundreds order.
   bit          model_on = 0;
   logic [10:0] m_cur, m_last, m_dp;
   int          m_run, m_have, m_val, m_addr;
   int          m_dig [3];
   bit          m_v, m_err, m_commit, m_defer, m_ev;

   task automatic model_digit(input logic [10:0] p);
      int v;
      int pos;
      v = -1;
      for (int i = 0; i < 10; i++) if (seg_code[i][6:0] == p[10:4]) v = i;
      case (p[3:0])
         BLANK:   return;
         ONES:    pos = 0;
         TENS:    pos = 1;
         HUNDS:   pos = 2;
         default: pos = -1;
      endcase
      if (pos < 0 || v < 0) begin
         m_err = 1; m_have = 0;
      end else if (pos == 0) begin
         m_dig[0] = v; m_have = 1;
      end else if (pos == m_have) begin
         m_dig[pos] = v;
         m_have++;
         if (m_have == 3) begin
            m_commit = 1;
            m_val = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
            m_have = 0;
         end
      end else begin
         m_err = 1; m_have = 0;
      end
   endtask

   always @(posedge clk) begin
      m_cur = {sseg_indicator[6:0], digits};
      m_v = 0;
      m_err = 0;
      if (!reset) begin
         m_run = 0; m_last = '0; m_have = 0; m_commit = 0; m_defer = 0; m_addr = 0;
      end else begin
         if (m_cur == m_last) m_run++;
         else m_run = 1;
         m_last = m_cur;
         m_ev = (m_run == S);
         if (m_commit) begin
            m_commit = 0;
            if (m_val <= 511) begin m_addr = m_val; m_v = 1; end
            else m_err = 1;
            if (m_ev && m_cur[3:0] != BLANK) begin m_defer = 1; m_dp = m_cur; end
         end else if (m_defer) begin
            m_defer = 0;
            model_digit(m_dp);
            if (m_ev && m_cur[3:0] != BLANK) begin m_defer = 1; m_dp = m_cur; end
         end else if (m_ev) begin
            model_digit(m_cur);
         end
      end
      model_on = 1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         checks++;
         if (address_line == 9'(m_addr) && address_valid == m_v && decode_error == m_err)
            passes++;
         else
            $display("FAIL cycle %0d outputs: actual addr=%0d valid=%0d err=%0d, required addr=%0d valid=%0d err=%0d",
                     cyc, address_line, address_valid, decode_error, m_addr, m_v, m_err);
         if (address_valid === 1'b1) begin valid_seen++; last_valid_cyc = cyc; end
         if (decode_error === 1'b1) err_seen++;
      end
   end

   task automatic show(input logic [7:0] s, input logic [3:0] d, input int n);
      @(negedge clk);
      sseg_indicator = s;
      digits = d;
      last_set_cyc = cyc;
      repeat (n) @(posedge clk);
   endtask

   task automatic digit(input int v, input logic [3:0] d);
      show(seg_code[v], d, 5);
      show(8'hFF, BLANK, 3);
   endtask

   int v0, e0, hund_set;

   initial begin
      reset = 1'b0;
      sseg_indicator = 8'hFF;
      digits = BLANK;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_addr", int'(address_line), 0);
      check("reset_valid", int'(address_valid), 0);
      check("reset_err", int'(decode_error), 0);
      reset = 1'b1;
      show(8'hFF, BLANK, 4);

      // Basic frame 123
      v0 = valid_seen; e0 = err_seen;
      digit(3, ONES);
      digit(2, TENS);
      show(seg_code[1], HUNDS, 5);
      hund_set = last_set_cyc;
      show(8'hFF, BLANK, 3);
      @(negedge clk);
      check("basic_addr", int'(address_line), 123);
      check("basic_valid_count", valid_seen - v0, 1);
      check("basic_err_count", err_seen - e0, 0);
      // hundreds registered at edge hund_set+1, commit S edges later
      check("basic_latency", last_valid_cyc, hund_set + 1 + S);

      // Range boundary
      v0 = valid_seen; e0 = err_seen;
      digit(1, ONES); digit(1, TENS); digit(5, HUNDS);
      @(negedge clk);
      check("range_511_addr", int'(address_line), 511);
      check("range_511_valid", valid_seen - v0, 1);
      v0 = valid_seen;
      digit(2, ONES); digit(1, TENS); digit(5, HUNDS);
      @(negedge clk);
      check("range_512_addr", int'(address_line), 511);
      check("range_512_err", err_seen - e0, 1);
      check("range_512_valid", valid_seen - v0, 0);

      // Glitch filter
      v0 = valid_seen; e0 = err_seen;
      show(8'h92, ONES, 2);
      show(8'hFF, BLANK, 3);
      @(negedge clk);
      check("glitch_err", err_seen - e0, 0);
      check("glitch_valid", valid_seen - v0, 0);
      show(8'h92, ONES, 3);
      show(8'hFF, BLANK, 3);
      digit(0, TENS); digit(0, HUNDS);
      @(negedge clk);
      check("glitch_accept_addr", int'(address_line), 5);
      check("glitch_accept_err", err_seen - e0, 0);

      // Illegal patterns
      e0 = err_seen;
      show(8'hFF, ONES, 5);
      show(8'hFF, BLANK, 3);
      check("illegal_seg_err", err_seen - e0, 1);
      show(8'hC0, 4'b1100, 5);
      show(8'hFF, BLANK, 3);
      @(negedge clk);
      check("illegal_sel_err", err_seen - e0, 2);
      check("illegal_addr", int'(address_line), 5);

      // Ordering
      e0 = err_seen; v0 = valid_seen;
      digit(4, TENS);
      check("order_tens_first_err", err_seen - e0, 1);
      digit(4, ONES); digit(7, ONES); digit(0, TENS); digit(3, HUNDS);
      @(negedge clk);
      check("order_addr", int'(address_line), 307);
      check("order_err", err_seen - e0, 1);
      check("order_valid", valid_seen - v0, 1);

      // Reset mid-frame
      digit(1, ONES); digit(2, TENS);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("midreset_addr", int'(address_line), 0);
      check("midreset_valid", int'(address_valid), 0);
      check("midreset_err", int'(decode_error), 0);
      reset = 1'b1;
      e0 = err_seen; v0 = valid_seen;
      digit(9, HUNDS);
      check("midreset_hund_err", err_seen - e0, 1);
      check("midreset_hund_valid", valid_seen - v0, 0);
      digit(0, ONES); digit(0, TENS); digit(0, HUNDS);
      @(negedge clk);
      check("zero_frame_valid", valid_seen - v0, 1);
      check("zero_frame_addr", int'(address_line), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/address_display_decoder.md
# address_display_decoder

Receive-side counterpart of the multiplexed seven-segment address display. The block monitors the scanned segment and digit-select lines and filters out transient patterns. It decodes each stable digit back to BCD, assembles a complete ones/tens/hundreds frame, and converts it to a 9-bit binary ROM address. It is used for bench self-checking of the ROM reader front panel and for loop-back capture on the board.

## Interface
- STABLE_CYCLES, 3: consecutive clocks a registered (digits, sseg_indicator) pair must stay unchanged before it is accepted; legal range 1..15.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on clk; 0 = reset.
- sseg_indicator  input  8  segment lines, active-low; bit7 = dp (ignored), bits6:0 = g..a.
- digits  input  4  digit selects, active-low; 1110 = ones, 1101 = tens, 1011 = hundreds, 1111 = blank.
- address_line  output  9  last successfully decoded address.
- address_valid  output  1  one-cycle pulse when address_line is updated.
- decode_error  output  1  one-cycle pulse on any rejected digit or frame.

## Operation
- **Input stage.** Both buses are registered once. stable_cnt resets to 1 when the registered pair differs from its previous value. Otherwise it increments, saturating at STABLE_CYCLES.
- **Digit event.** A digit event fires exactly once per stable period: the cycle stable_cnt reaches STABLE_CYCLES. Saturation prevents a second event for the same held pattern.
- **Segment decode** (bits6:0, active-low): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9. Any other pattern is illegal.
- **Digit select.** digits = 1111 is blank: the event is ignored, with no state change and no error. Any select other than 1110, 1101, 1011 or 1111 is illegal.
- **FSM states:** WAIT_ONES, WAIT_TENS, WAIT_HUNDREDS, COMMIT. Reset state is WAIT_ONES.
- **Legal ones event.** In any state except COMMIT, latch ones and go to WAIT_TENS. A ones event in WAIT_TENS or WAIT_HUNDREDS restarts the frame without raising an error.
- **Legal tens event.** In WAIT_TENS, latch tens and go to WAIT_HUNDREDS. A tens event in any other state is out of order.
- **Legal hundreds event.** In WAIT_HUNDREDS, latch hundreds and go to COMMIT. A hundreds event in any other state is out of order.
- **COMMIT** lasts one cycle:
  - Compute value = h*100 + t*10 + o in 10 bits, maximum 999.
  - If value ≤ 511: address_line ← value[8:0] and pulse address_valid.
  - Otherwise: pulse decode_error and leave address_line unchanged.
  - Then return to WAIT_ONES.
- **Errors.** An illegal segment pattern, illegal select, or out-of-order digit pulses decode_error, discards the partial frame and returns to WAIT_ONES.
- **Events during COMMIT.** A digit event arriving while in COMMIT is evaluated against WAIT_ONES in the following cycle. It is held in a one-deep pending register; it is not dropped.
- address_line holds its value between valid commits.
- address_valid and decode_error are never asserted in the same cycle.

## Timing
- **Reset values:** address_line = 0, address_valid = 0, decode_error = 0, state WAIT_ONES, stable_cnt = 0, latched digits = 0, pending empty.
- **Reset priority.** Reset mid-frame discards all partial digits. Reset takes priority over every event in the same cycle.
- **Capture latency.** Inputs first presented before edge E and held are registered at E. The digit event occurs at edge E+STABLE_CYCLES−1, and the digit is latched or rejected at that edge.
- **Commit latency.** address_line, address_valid and commit-range errors appear one edge after the hundreds digit is latched, i.e. at E+STABLE_CYCLES.
- **Minimum hold.** A pattern held for fewer than STABLE_CYCLES consecutive registered samples never produces an event.
- **Same pattern on adjacent digits.** Two consecutive digits showing the same segment pattern are distinguished by the digits bus. A change of either bus restarts stable_cnt.
- **Throughput.** One frame per three accepted digit events. There is no back-pressure; outputs are pulses only.

## Test plan
- **Basic frame, STABLE_CYCLES = 3.** Ones B0/1110, tens A4/1101, hundreds F9/1011, each held 5 cycles with 1111 blanks between. Required: address_line = 123 and a single address_valid pulse 3 edges after hundreds is first registered.
- **Range boundary.** Digits 1,1,5 (ones first) → address_line = 511 (0x1FF) with valid. Then digits 2,1,5 → decode_error pulse; address_line stays 511.
- **Glitch filter.** Ones pattern 92 held 2 cycles, then switched to blank. Required: no event, no error, state stays WAIT_ONES. The same pattern held 3 cycles is accepted.
- **Illegal patterns.** Segment FF with digits 1110 → decode_error. Digits 1100 with C0 → decode_error. Both leave address_line unchanged.
- **Ordering.** A tens digit first → decode_error. Sequence ones=4, ones=7, tens=0, hundreds=3 → address_line = 307 with no error (the second ones restarts the frame).
- **Reset mid-frame.** Reset low for 1 cycle after ones and tens are accepted. Required: all outputs 0. A following hundreds digit alone → decode_error with no valid. A full frame 0,0,0 → valid with address_line = 0.
